reg_lock_table: RTL

- Architectural register scoreboard; sits directly upstream of the issue-stage register grant checker.
- Holds one lock bit per integer register, supplies the checker's current lock vector, and sets the destination lock when the arbiter grants an instruction.
- Clears locks on write-back.
- Holds a global all-locked state from a granted jump until the jump resolves.

---
 rtl/rv64g_pkg.sv | 19 +
 rtl/reg_lock_popcount.sv | 17 +
 rtl/reg_lock_table.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rv64g_pkg.sv
// Shared RV64G core definitions: register file size, write-back port count,
// register lock scoreboard state encoding and a one-hot decode helper.
package rv64g_pkg;

  localparam int NUM_REGS     = 32;
  localparam int NUM_WB_PORTS = 2;

  typedef enum logic {
    LT_RUN       = 1'b0,
    LT_JUMP_PEND = 1'b1
  } reg_lock_state_e;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [$clog2(NUM_REGS)-1:0] idx);
    logic [NUM_REGS-1:0] w_one;
    w_one = {{(NUM_REGS-1){1'b0}}, 1'b1};
    return w_one << idx;
  endfunction

endpackage

// File: rtl/reg_lock_popcount.sv
// Combinational ones-counter over a W-bit vector.
module reg_lock_popcount #(
  parameter  int W  = 32,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec_i,
  output logic [CW-1:0] cnt_o
);

  always_comb begin
    cnt_o = {CW{1'b0}};
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + CW'(vec_i[i]);
    end
  end

endmodule

// File: rtl/reg_lock_table.sv
// Architectural register lock scoreboard: per-register locks set on grant,
// cleared on write-back, plus a global all-locked window while a jump resolves.
module reg_lock_table
  import rv64g_pkg::*;
#(
  parameter  int NWB = NUM_WB_PORTS,
  localparam int NR  = NUM_REGS,
  localparam int RW  = $clog2(NR),
  localparam int CW  = RW + 1
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              gnt_i,
  input  logic              jump_i,
  input  logic [RW-1:0]     rd_i,
  input  logic [NWB-1:0]    wb_valid_i,
  input  logic [NWB*RW-1:0] wb_rd_i,
  input  logic              jump_done_i,
  output logic [NR-1:0]     locks_o,
  output logic [CW-1:0]     lock_cnt_o,
  output logic              idle_o,
  output logic              jump_pend_o,
  output logic              err_o
);

  logic [NR-1:0]   r_table;
  logic [CW-1:0]   r_cnt;
  logic            r_err;
  reg_lock_state_e r_state;

  logic [NR-1:0]   w_clr_vec;
  logic [NR-1:0]   w_set_vec;
  logic [NR-1:0]   w_table_next;
  logic [CW-1:0]   w_cnt_next;
  logic            w_err_next;
  reg_lock_state_e w_state_next;

  // Lock table update and protocol-violation detection.
  always_comb begin
    w_clr_vec  = {NR{1'b0}};
    w_set_vec  = {NR{1'b0}};
    w_err_next = 1'b0;
    if (gnt_i) begin
      w_set_vec = reg_onehot(rd_i);
      if ((rd_i != {RW{1'b0}}) && r_table[rd_i]) begin
        w_err_next = 1'b1;
      end else begin
        w_err_next = w_err_next;
      end
    end else begin
      w_set_vec = {NR{1'b0}};
    end
    for (int p = 0; p < NWB; p++) begin
      if (wb_valid_i[p]) begin
        w_clr_vec = w_clr_vec | reg_onehot(wb_rd_i[p*RW +: RW]);
        if ((wb_rd_i[p*RW +: RW] != {RW{1'b0}}) && !r_table[wb_rd_i[p*RW +: RW]]
            && !w_set_vec[wb_rd_i[p*RW +: RW]]) begin
          w_err_next = 1'b1;
        end else begin
          w_err_next = w_err_next;
        end
      end else begin
        w_clr_vec = w_clr_vec;
      end
      for (int q = p + 1; q < NWB; q++) begin
        if (wb_valid_i[p] && wb_valid_i[q] && (wb_rd_i[p*RW +: RW] == wb_rd_i[q*RW +: RW])
            && (wb_rd_i[p*RW +: RW] != {RW{1'b0}})) begin
          w_err_next = 1'b1;
        end else begin
          w_err_next = w_err_next;
        end
      end
    end
    if (jump_done_i && (r_state == LT_RUN)) begin
      w_err_next = 1'b1;
    end else begin
      w_err_next = w_err_next;
    end
    // Set is ORed in last so it wins over a same-cycle clear; x0 never locks.
    w_table_next    = (r_table & ~w_clr_vec) | w_set_vec;
    w_table_next[0] = 1'b0;
  end

  // Jump window FSM next state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LT_RUN: begin
        if (gnt_i && jump_i) begin
          w_state_next = LT_JUMP_PEND;
        end else begin
          w_state_next = LT_RUN;
        end
      end
      LT_JUMP_PEND: begin
        if (jump_done_i) begin
          w_state_next = LT_RUN;
        end else begin
          w_state_next = LT_JUMP_PEND;
        end
      end
      default: w_state_next = LT_RUN;
    endcase
  end

  reg_lock_popcount #(.W(NR)) u_popcount (
    .vec_i (w_table_next),
    .cnt_o (w_cnt_next)
  );

  // State registers; the count is taken from the next table so it never lags.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_table <= {NR{1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_err   <= 1'b0;
      r_state <= LT_RUN;
    end else begin
      r_table <= w_table_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
      r_state <= w_state_next;
    end
  end

  assign locks_o     = (r_state == LT_JUMP_PEND) ? {NR{1'b1}} : r_table;
  assign lock_cnt_o  = r_cnt;
  assign idle_o      = (r_state == LT_RUN) && (r_cnt == {CW{1'b0}});
  assign jump_pend_o = (r_state == LT_JUMP_PEND);
  assign err_o       = r_err;

endmodule
